// File: rtl/frogger_game_ctrl_if.sv
// Purpose : groups the frogger game sequencer's event inputs and status outputs.
// Latency : n/a (wiring only).
// Backpressure : none; all inputs are level/strobe signals sampled every clk.
// Ports   : tick/start/ack/hit/victory toward the sequencer; state, lives, level,
//           speed, score, respawn, freeze, game_over back to the datapath.
interface frogger_game_ctrl_if;
    logic       tick_i;
    logic       start_i;
    logic       ack_i;
    logic       hit_i;
    logic       victory_i;
    logic [4:0] state_o;
    logic [1:0] lives_o;
    logic [2:0] level_o;
    logic [4:0] speed_o;
    logic [7:0] score_o;
    logic       respawn_o;
    logic       freeze_o;
    logic       game_over_o;

    // master: the side producing game events (datapath / bench)
    modport master (
        output tick_i, start_i, ack_i, hit_i, victory_i,
        input  state_o, lives_o, level_o, speed_o, score_o,
               respawn_o, freeze_o, game_over_o
    );

    // slave: the sequencer itself
    modport slave (
        input  tick_i, start_i, ack_i, hit_i, victory_i,
        output state_o, lives_o, level_o, speed_o, score_o,
               respawn_o, freeze_o, game_over_o
    );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Purpose : frogger game sequencer - lives, level/speed, BCD score, respawn/level-up pauses.
// Latency : state/counters update 1 clk after the triggering input; pauses last N tick strobes.
// Backpressure : none; hit/victory are ignored outside PLAY, start/ack only act as rising edges.
// Ports   : clk, reset_n (async active-low), bus (slave modport of frogger_game_ctrl_if).
module frogger_game_ctrl #(
    parameter int LIVES_INIT    = 3,
    parameter int RESPAWN_TICKS = 30,
    parameter int LEVELUP_TICKS = 60,
    parameter int MAX_LEVEL     = 7,
    parameter int SPEED_BASE    = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    frogger_game_ctrl_if.slave   bus
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_PLAY    = 5'b00010,
        S_RESPAWN = 5'b00100,
        S_LEVELUP = 5'b01000,
        S_OVER    = 5'b10000
    } state_t;

    localparam int TMAX = (RESPAWN_TICKS > LEVELUP_TICKS) ? RESPAWN_TICKS : LEVELUP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_n;
    logic [1:0]    lives, lives_n;
    logic [2:0]    level, level_n;
    logic [7:0]    score, score_n;
    logic [TW-1:0] timer, timer_n;
    logic          respawn, respawn_n;
    logic          start_q, ack_q;
    logic          start_rise, ack_rise;

    assign start_rise = bus.start_i & ~start_q;
    assign ack_rise   = bus.ack_i & ~ack_q;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        else if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        else
            return {s[7:4], s[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            lives   <= 2'(LIVES_INIT);
            level   <= 3'd0;
            score   <= 8'h00;
            timer   <= '0;
            respawn <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_n;
            lives   <= lives_n;
            level   <= level_n;
            score   <= score_n;
            timer   <= timer_n;
            respawn <= respawn_n;
            start_q <= bus.start_i;
            ack_q   <= bus.ack_i;
        end
    end

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        level_n   = level;
        score_n   = score;
        timer_n   = timer;
        respawn_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Reload every clk so leaving OVER restores a fresh game one clk later.
                lives_n = 2'(LIVES_INIT);
                level_n = 3'd0;
                score_n = 8'h00;
                if (start_rise) begin
                    state_n   = S_PLAY;
                    respawn_n = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.victory_i) begin
                    // Reaching the goal wins even if a car overlaps in the same cycle.
                    score_n = bcd_inc(score);
                    level_n = (level >= 3'(MAX_LEVEL)) ? level : level + 3'd1;
                    timer_n = TW'(LEVELUP_TICKS);
                    state_n = S_LEVELUP;
                end else if (bus.hit_i) begin
                    if (lives > 2'd1) begin
                        lives_n = lives - 2'd1;
                        timer_n = TW'(RESPAWN_TICKS);
                        state_n = S_RESPAWN;
                    end else begin
                        lives_n = 2'd0;
                        state_n = S_OVER;
                    end
                end
            end
            S_RESPAWN, S_LEVELUP: begin
                if (bus.tick_i) begin
                    if (timer == TW'(1)) begin
                        timer_n   = '0;
                        state_n   = S_PLAY;
                        respawn_n = 1'b1;
                    end else begin
                        timer_n = timer - TW'(1);
                    end
                end
            end
            S_OVER: begin
                if (ack_rise)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.state_o     = state;
    assign bus.lives_o     = lives;
    assign bus.level_o     = level;
    assign bus.score_o     = score;
    assign bus.speed_o     = 5'(SPEED_BASE) + {2'b00, level};
    assign bus.respawn_o   = respawn;
    assign bus.freeze_o    = (state != S_PLAY);
    assign bus.game_over_o = (state == S_OVER);

endmodule
